// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Brief   : Shared UART state encodings, frame constants and baud helper.    |
// |           Parity states exist only when UART_PARITY_EN is defined.         |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx                                                          |
// | Brief   : UART receiver: 2-flop synchroniser, mid-bit sampling FSM.        |
// |           UART_PARITY_EN adds an even-parity bit and o_rx_perr.            |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
`ifdef UART_PARITY_EN
  output logic                 o_rx_perr,
`endif
  output logic [DATA_BITS-1:0] o_rxout,
  output logic                 o_rxdone
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_idx_w = $clog2(DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_BITS - 1);

  logic                 r_sync1, r_sync2;
  logic                 w_rx;
  rx_state_t            r_state, w_state_next;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
  logic [c_idx_w-1:0]   r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_rxout, w_rxout_next;
  logic                 r_rxdone, w_rxdone_next;
  logic                 r_armed, w_armed_next;
  logic                 w_bit_end;
`ifdef UART_PARITY_EN
  logic                 r_par, w_par_next;
  logic                 r_perr, w_perr_next;
`endif

  assign w_rx      = r_sync2;
  assign w_bit_end = (r_cnt == c_bit_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_next;
  end

  // After a framing error the line must be seen high before a new start is accepted.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + c_cnt_w'(1);
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
    w_rxout_next  = r_rxout;
    w_rxdone_next = 1'b0;
    w_armed_next  = r_armed;
`ifdef UART_PARITY_EN
    w_par_next    = r_par;
    w_perr_next   = r_perr;
`endif
    case (r_state)
      RX_IDLE: begin
        w_cnt_next   = '0;
        w_armed_next = r_armed | w_rx;
        if (r_armed && !w_rx) w_state_next = RX_START;
      end
      RX_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rx, r_shift[DATA_BITS-1:1]};
          w_idx_next   = r_idx + c_idx_w'(1);
          if (r_idx == c_idx_last) begin
`ifdef UART_PARITY_EN
            w_state_next = RX_PARITY;
`else
            w_state_next = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_par_next   = w_rx;
          w_state_next = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_state_next = RX_IDLE;
          if (w_rx) begin
            w_rxout_next  = r_shift;
            w_rxdone_next = 1'b1;
`ifdef UART_PARITY_EN
            w_perr_next   = r_par ^ (^r_shift);
`endif
          end else begin
            w_armed_next = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = RX_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_rxout  <= '0;
      r_rxdone <= 1'b0;
      r_armed  <= 1'b0;
`ifdef UART_PARITY_EN
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
`endif
    end else begin
      r_sync1  <= i_rx;
      r_sync2  <= r_sync1;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_rxout  <= w_rxout_next;
      r_rxdone <= w_rxdone_next;
      r_armed  <= w_armed_next;
`ifdef UART_PARITY_EN
      r_par    <= w_par_next;
      r_perr   <= w_perr_next;
`endif
    end
  end

  assign o_rxout  = r_rxout;
  assign o_rxdone = r_rxdone;
`ifdef UART_PARITY_EN
  assign o_rx_perr = r_perr;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_core                                                        |
// | Brief   : Full-duplex 8N1 UART; TX FSM inline, receiver in uart_rx.        |
// |           UART_PARITY_EN adds an even-parity bit and the rx_perr port.     |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] txin,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rxout,
  output logic                 rxdone,
`ifdef UART_PARITY_EN
  output logic                 rx_perr,
`endif
  output logic                 txdone
);

  localparam int c_clks_per_bit = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int c_cnt_w = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
  localparam int c_idx_w = $clog2(DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);

  tx_state_t            r_tx_state, w_tx_state_next;
  logic [c_cnt_w-1:0]   r_tx_cnt, w_tx_cnt_next;
  logic [c_idx_w-1:0]   r_tx_idx, w_tx_idx_next;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 w_tx_bit_end;
  logic                 w_txdone;
`ifdef UART_PARITY_EN
  logic                 r_tx_par, w_tx_par_next;
`endif

  assign w_tx_bit_end = (r_tx_cnt == c_bit_last);

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_state_next;
  end

  // tx is registered from the next-state decision so the pin never glitches.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt + c_cnt_w'(1);
    w_tx_idx_next   = r_tx_idx;
    w_tx_shift_next = r_tx_shift;
    w_tx_next       = r_tx;
    w_txdone        = 1'b0;
`ifdef UART_PARITY_EN
    w_tx_par_next   = r_tx_par;
`endif
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_next = '0;
        w_tx_next     = 1'b1;
        if (start) begin
          w_tx_state_next = TX_START;
          w_tx_shift_next = txin;
          w_tx_idx_next   = '0;
          w_tx_next       = 1'b0;
`ifdef UART_PARITY_EN
          w_tx_par_next   = ^txin;
`endif
        end
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_state_next = TX_DATA;
          w_tx_next       = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_shift_next = r_tx_shift >> 1;
          w_tx_idx_next   = r_tx_idx + c_idx_w'(1);
          if (r_tx_idx == c_idx_last) begin
`ifdef UART_PARITY_EN
            w_tx_state_next = TX_PARITY;
            w_tx_next       = r_tx_par;
`else
            w_tx_state_next = TX_STOP;
            w_tx_next       = 1'b1;
`endif
          end else begin
            w_tx_next = r_tx_shift[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_state_next = TX_STOP;
          w_tx_next       = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_state_next = TX_IDLE;
          w_tx_next       = 1'b1;
          w_txdone        = 1'b1;
        end
      end
      default: begin
        w_tx_state_next = TX_IDLE;
        w_tx_cnt_next   = '0;
        w_tx_next       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx       <= w_tx_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_shift <= w_tx_shift_next;
`ifdef UART_PARITY_EN
      r_tx_par   <= w_tx_par_next;
`endif
    end
  end

  assign tx     = r_tx;
  assign txdone = w_txdone;

  uart_rx #(
    .CLKS_PER_BIT(c_clks_per_bit)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .i_rx     (rx),
`ifdef UART_PARITY_EN
    .o_rx_perr(rx_perr),
`endif
    .o_rxout  (rxout),
    .o_rxdone (rxdone)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_core                                                     |
// | Brief   : Self-checking bench for uart_core with a frame-level model.      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_core;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] txin = 8'h00;
  logic       tx, rx, rxdone, txdone;
  logic [7:0] rxout;
  logic       loop = 1'b1;
  logic       rx_drv = 1'b1;
`ifdef UART_PARITY_EN
  logic       rx_perr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rx_cnt  = 0;
  int tx_cnt  = 0;
  int rx_cyc  = 0;
  logic [7:0] rx_q[$];
  int         tx_cq[$];

  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .txin   (txin),
    .tx     (tx),
    .rx     (rx),
    .rxout  (rxout),
    .rxdone (rxdone),
`ifdef UART_PARITY_EN
    .rx_perr(rx_perr),
`endif
    .txdone (txdone)
  );

  always @(negedge clk) begin
    if (rxdone === 1'b1) begin
      rx_q.push_back(rxout);
      rx_cnt++;
      rx_cyc = cyc;
    end
    if (txdone === 1'b1) begin
      tx_cq.push_back(cyc);
      tx_cnt++;
    end
  end

  // Line level of bit k of a frame carrying d, with the given stop value.
  function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (NBITS == 11 && k == 9) return ^d;
    return stop;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_txdone(input string tag);
    int k;
    k = 0;
    while (txdone !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < 500), 32'd1);
  endtask

  // Sends d over the looped line and checks every clock of the waveform.
  task automatic send_and_check(input logic [7:0] d);
    int rx0;
    int tx0;
    rx0 = rx_cnt;
    tx0 = tx_cnt;
    txin  = d;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    txin  = ~d;
    for (int o = 0; o < NBITS * CPB; o++) begin
      check("tx_wave", 32'(tx), 32'(frame_bit(d, o / CPB, 1'b1)));
      check("txdone_time", 32'(txdone), 32'(o == NBITS * CPB - 1));
      tick(1);
    end
    check("tx_idle_after", 32'(tx), 32'd1);
    check("txdone_count", 32'(tx_cnt), 32'(tx0 + 1));
    check("rxdone_count", 32'(rx_cnt), 32'(rx0 + 1));
    check("rxout_loop", 32'(rxout), 32'(d));
    check("rx_before_tx", 32'(rx_cyc < tx_cq[tx_cq.size() - 1]), 32'd1);
`ifdef UART_PARITY_EN
    check("rx_perr_loop", 32'(rx_perr), 32'd0);
`endif
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    for (int k = 0; k < NBITS; k++) begin
      rx_drv = frame_bit(d, k, stop);
      tick(CPB);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] bytes[10];
    int base;
    int tbase;

    // Reset state
    tick(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rxout", 32'(rxout), 32'h00);
    check("rst_rxdone", 32'(rxdone), 32'd0);
    check("rst_txdone", 32'(txdone), 32'd0);
`ifdef UART_PARITY_EN
    check("rst_rx_perr", 32'(rx_perr), 32'd0);
`endif
    rst = 1'b0;
    tick(5);

    // Single looped frame
    send_and_check(8'hA5);
    tick(10);

    // Back-to-back frames with start held
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom_range(200, 10));
    base  = rx_cnt;
    tbase = tx_cq.size();
    txin  = bytes[0];
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_txdone("held_txdone_wait");
      tick(1);
      if (i < 9) txin = bytes[i + 1];
      else start = 1'b0;
    end
    tick(40);
    check("held_rx_count", 32'(rx_cnt), 32'(base + 10));
    for (int i = 0; i < 10; i++)
      check("held_rx_byte", 32'(rx_q[base + i]), 32'(bytes[i]));
    for (int i = 1; i < 10; i++)
      check("held_gap", 32'(tx_cq[tbase + i] - tx_cq[tbase + i - 1]), 32'(NBITS * CPB + 1));
    check("held_stopped", 32'(tx_cq.size()), 32'(tbase + 10));

    // False start on rx-only drive
    loop   = 1'b0;
    rx_drv = 1'b1;
    tick(20);
    base   = rx_cnt;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(60);
    check("glitch_no_rxdone", 32'(rx_cnt), 32'(base));

    // Line held low
    rx_drv = 1'b0;
    tick(400);
    rx_drv = 1'b1;
    tick(40);
    check("low_no_rxdone", 32'(rx_cnt), 32'(base));

    // Framing error then a good frame
    send_rx(8'h5A, 1'b0);
    tick(40);
    check("ferr_no_rxdone", 32'(rx_cnt), 32'(base));
    check("ferr_rxout_held", 32'(rxout), 32'(bytes[9]));
    send_rx(8'h3C, 1'b1);
    tick(40);
    check("good_rx_count", 32'(rx_cnt), 32'(base + 1));
    check("good_rxout", 32'(rxout), 32'h3C);

    // Reset mid-frame
    loop  = 1'b1;
    tick(5);
    base  = rx_cnt;
    tbase = tx_cnt;
    txin  = 8'hFF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(CPB * 4 + 5);
    rst = 1'b1;
    tick(1);
    check("midrst_tx_high", 32'(tx), 32'd1);
    check("midrst_txdone", 32'(txdone), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(200);
    check("midrst_no_txdone", 32'(tx_cnt), 32'(tbase));
    check("midrst_no_rxdone", 32'(rx_cnt), 32'(base));
    check("midrst_rxout", 32'(rxout), 32'h00);
    check("midrst_tx_idle", 32'(tx), 32'd1);
    send_and_check(8'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
